// File: rtl/lu_arbiter_if.sv
// Handshake bundle for lu_arbiter: two command ports and one result port.
// The master modport is the requester/consumer side and the slave modport is the arbiter side.
interface lu_arbiter_if #(parameter int WIDTH = 4);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [1:0]       req0_op;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [1:0]       req1_op;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_id;
    logic             res_zero;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_data, res_id, res_zero
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_data, res_id, res_zero
    );
endinterface

// File: rtl/lu_arbiter.sv
// Two-port arbiter in front of a shared MOV/XOR/OR/AND unit with a one-deep registered result.
// The default build uses round-robin arbitration. Defining LU_ARB_FIXED_PRIO_EN gives port 0 fixed priority.
module lu_arbiter_lane #(parameter int WIDTH = 4) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] y
);
    always_comb begin
        y = '0;
        case (op)
            2'b00:   y = b;
            2'b01:   y = a ^ b;
            2'b10:   y = a | b;
            default: y = a & b;
        endcase
    end
endmodule

module lu_arbiter #(parameter int WIDTH = 4) (
    input  logic        clk,
    input  logic        rst_n,
    lu_arbiter_if.slave bus
);
    typedef enum logic {IDLE, FULL} state_t;

    state_t                 state;
    logic                   last_grant;
    logic                   can_accept;
    logic [1:0]             vld;
    logic [1:0]             gnt;
    logic [1:0][WIDTH-1:0]  a_l;
    logic [1:0][WIDTH-1:0]  b_l;
    logic [1:0][1:0]        op_l;
    logic [1:0][WIDTH-1:0]  y_l;
    logic [WIDTH-1:0]       y_sel;

    assign vld  = {bus.req1_valid, bus.req0_valid};
    assign a_l  = {bus.req1_a, bus.req0_a};
    assign b_l  = {bus.req1_b, bus.req0_b};
    assign op_l = {bus.req1_op, bus.req0_op};

    // Each port gets its own unit so the result mux is the only logic that depends on the grant.
    for (genvar i = 0; i < 2; i++) begin : g_lane
        lu_arbiter_lane #(.WIDTH(WIDTH)) u_lane (
            .a  (a_l[i]),
            .b  (b_l[i]),
            .op (op_l[i]),
            .y  (y_l[i])
        );
    end

    assign can_accept = (state == IDLE) | bus.res_ready;

`ifdef LU_ARB_FIXED_PRIO_EN
    assign gnt[0] = can_accept & vld[0];
    assign gnt[1] = can_accept & vld[1] & ~vld[0];
`else
    // On a tie, the port that was not granted last time wins.
    assign gnt[0] = can_accept & vld[0] & (~vld[1] | last_grant);
    assign gnt[1] = can_accept & vld[1] & (~vld[0] | ~last_grant);
`endif

    assign bus.req0_ready = gnt[0];
    assign bus.req1_ready = gnt[1];
    assign y_sel          = gnt[1] ? y_l[1] : y_l[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            bus.res_id    <= 1'b0;
            bus.res_zero  <= 1'b1;
        end else if (|gnt) begin
            // A grant reloads the result register, even when the old result is being delivered on the same edge.
            state         <= FULL;
            last_grant    <= gnt[1];
            bus.res_valid <= 1'b1;
            bus.res_data  <= y_sel;
            bus.res_id    <= gnt[1];
            bus.res_zero  <= (y_sel == '0);
        end else if (state == FULL && bus.res_ready) begin
            state         <= IDLE;
            bus.res_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_lu_arbiter.sv
// Table-driven self-checking bench for lu_arbiter. Expected results go through a scoreboard queue.
module tb_lu_arbiter;
    localparam int WIDTH = 4;

    typedef struct {
        string            name;
        logic             v0;
        logic [WIDTH-1:0] a0;
        logic [WIDTH-1:0] b0;
        logic [1:0]       op0;
        logic             v1;
        logic [WIDTH-1:0] a1;
        logic [WIDTH-1:0] b1;
        logic [1:0]       op1;
        logic             rr;
        logic [1:0]       eg;   // expected {req1_ready, req0_ready}
        logic [WIDTH-1:0] ed;   // expected result of the granted command
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic exp_full = 1'b0;
    logic [WIDTH:0] sb[$];      // {id, data}
    vec_t tbl[$];

    lu_arbiter_if #(.WIDTH(WIDTH)) bus();

    lu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name,
                                input logic v0, input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0, input logic [1:0] op0,
                                input logic v1, input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1, input logic [1:0] op1,
                                input logic rr, input logic [1:0] eg, input logic [WIDTH-1:0] ed);
        vec_t v;
        v.name = name; v.v0 = v0; v.a0 = a0; v.b0 = b0; v.op0 = op0;
        v.v1 = v1; v.a1 = a1; v.b1 = b1; v.op1 = op1;
        v.rr = rr; v.eg = eg; v.ed = ed;
        return v;
    endfunction

    // The task drives one cycle, checks the combinational readies and the held result at the negedge, then advances.
    task automatic step(input vec_t v);
        bus.req0_valid = v.v0; bus.req0_a = v.a0; bus.req0_b = v.b0; bus.req0_op = v.op0;
        bus.req1_valid = v.v1; bus.req1_a = v.a1; bus.req1_b = v.b1; bus.req1_op = v.op1;
        bus.res_ready  = v.rr;
        @(negedge clk);
        chk({v.name, " ready"}, 32'({bus.req1_ready, bus.req0_ready}), 32'(v.eg));
        chk({v.name, " res_valid"}, 32'(bus.res_valid), 32'(exp_full));
        if (exp_full) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL %s scoreboard: got empty queue expected pending result", v.name);
            end else begin
                chk({v.name, " res_data"}, 32'(bus.res_data), 32'(sb[0][WIDTH-1:0]));
                chk({v.name, " res_id"},   32'(bus.res_id),   32'(sb[0][WIDTH]));
                chk({v.name, " res_zero"}, 32'(bus.res_zero), 32'(sb[0][WIDTH-1:0] == '0));
                if (v.rr) void'(sb.pop_front());
            end
        end
        if (v.eg != 2'b00) sb.push_back({v.eg[1], v.ed});
        @(posedge clk); #1;
        if (v.eg != 2'b00) exp_full = 1'b1;
        else if (v.rr)     exp_full = 1'b0;
    endtask

    task automatic do_reset(input string name);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.res_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        exp_full = 1'b0;
        chk({name, " rst res_valid"}, 32'(bus.res_valid), 32'd0);
        chk({name, " rst res_data"},  32'(bus.res_data),  32'd0);
        chk({name, " rst res_id"},    32'(bus.res_id),    32'd0);
        chk({name, " rst res_zero"},  32'(bus.res_zero),  32'd1);
    endtask

    initial begin
        logic [1:0] g_tie0, g_tie1, g_tie2, g_tie3, g_hold, g_rel;
        logic [WIDTH-1:0] d_tie0, d_tie1, d_tie2, d_tie3, d_hold, d_rel;
`ifdef LU_ARB_FIXED_PRIO_EN
        g_tie0 = 2'b01; g_tie1 = 2'b01; g_tie2 = 2'b01; g_tie3 = 2'b01;
        d_tie0 = 4'h3;  d_tie1 = 4'h3;  d_tie2 = 4'h3;  d_tie3 = 4'h3;
        g_hold = 2'b01; d_hold = 4'h6;
        g_rel  = 2'b01; d_rel  = 4'h6;
`else
        // last_grant is 0 going into the tie burst, so port 1 is granted first.
        g_tie0 = 2'b10; g_tie1 = 2'b01; g_tie2 = 2'b10; g_tie3 = 2'b01;
        d_tie0 = 4'hC;  d_tie1 = 4'h3;  d_tie2 = 4'hC;  d_tie3 = 4'h3;
        g_hold = 2'b10; d_hold = 4'h9;
        g_rel  = 2'b01; d_rel  = 4'h6;
`endif
        //             name      v0 a0   b0   op0    v1 a1   b1   op1    rr  eg     ed
        tbl.push_back(mk("and0", 1, 4'hC, 4'hA, 2'b11, 0, 4'h0, 4'h0, 2'b00, 1, 2'b01, 4'h8));
        tbl.push_back(mk("xor1", 0, 4'h0, 4'h0, 2'b00, 1, 4'h5, 4'h5, 2'b01, 1, 2'b10, 4'h0));
        tbl.push_back(mk("mov1", 0, 4'h0, 4'h0, 2'b00, 1, 4'h3, 4'h7, 2'b00, 1, 2'b10, 4'h7));
        tbl.push_back(mk("or0",  1, 4'h9, 4'h4, 2'b10, 0, 4'h0, 4'h0, 2'b00, 1, 2'b01, 4'hD));
        tbl.push_back(mk("drain",0, 4'h0, 4'h0, 2'b00, 0, 4'h0, 4'h0, 2'b00, 1, 2'b00, 4'h0));
        tbl.push_back(mk("idle", 0, 4'h0, 4'h0, 2'b00, 0, 4'h0, 4'h0, 2'b00, 0, 2'b00, 4'h0));
        tbl.push_back(mk("tie0", 1, 4'hF, 4'h3, 2'b11, 1, 4'hF, 4'h3, 2'b01, 1, g_tie0, d_tie0));
        tbl.push_back(mk("tie1", 1, 4'hF, 4'h3, 2'b11, 1, 4'hF, 4'h3, 2'b01, 1, g_tie1, d_tie1));
        tbl.push_back(mk("tie2", 1, 4'hF, 4'h3, 2'b11, 1, 4'hF, 4'h3, 2'b01, 1, g_tie2, d_tie2));
        tbl.push_back(mk("tie3", 1, 4'hF, 4'h3, 2'b11, 1, 4'hF, 4'h3, 2'b01, 1, g_tie3, d_tie3));
        tbl.push_back(mk("drn2", 0, 4'h0, 4'h0, 2'b00, 0, 4'h0, 4'h0, 2'b00, 1, 2'b00, 4'h0));

        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
        bus.res_ready  = 1'b0;
        do_reset("init");

        foreach (tbl[i]) step(tbl[i]);

        // The result stays held while res_ready is 0, and the release cycle grants in that same cycle.
        // The MOV payloads differ per port, so the data check shows which port won.
        step(mk("hld_ld", 1, 4'h0, 4'h6, 2'b00, 1, 4'h0, 4'h9, 2'b00, 0, g_hold, d_hold));
        for (int k = 0; k < 5; k++)
            step(mk($sformatf("hold%0d", k), 1, 4'h0, 4'h6, 2'b00, 1, 4'h0, 4'h9, 2'b00, 0, 2'b00, 4'h0));
        step(mk("hld_rel", 1, 4'h0, 4'h6, 2'b00, 1, 4'h0, 4'h9, 2'b00, 1, g_rel, d_rel));
        step(mk("drn3", 0, 4'h0, 4'h0, 2'b00, 0, 4'h0, 4'h0, 2'b00, 1, 2'b00, 4'h0));

        // Load from port 0 so last_grant is 0, then reset while FULL. The next tie must still go to port 0.
        step(mk("pre_rst", 1, 4'h0, 4'h5, 2'b00, 0, 4'h0, 4'h0, 2'b00, 0, 2'b01, 4'h5));
        chk("pre_rst full", 32'(bus.res_valid), 32'd1);
        do_reset("mid");
        step(mk("tie_rst", 1, 4'h1, 4'h2, 2'b10, 1, 4'hE, 4'hC, 2'b11, 1, 2'b01, 4'h3));
        step(mk("drn4", 0, 4'h0, 4'h0, 2'b00, 0, 4'h0, 4'h0, 2'b00, 1, 2'b00, 4'h0));
        chk("sb empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
